// File: rtl/usb3_if_pkg.sv
`default_nettype none
// ============================================================================
// usb3_if_pkg : shared types and defaults for the FT60x receive bridge
// Revision    : 1.0 - initial release
// ============================================================================
package usb3_if_pkg;

  localparam int c_data_w = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OE   = 2'd1,
    ST_READ = 2'd2,
    ST_STOP = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/usb3_if_if.sv
`default_nettype none
// ============================================================================
// usb3_if_if : FTDI-side strobes/bus plus downstream FIFO pop port
// Revision   : 1.0 - initial release
// ============================================================================
interface usb3_if_if #(
  parameter int DATA_W = 32
);
  logic              FR_RXF;
  logic              FT_OE;
  logic              FT_RD;
  logic [DATA_W-1:0] usb3_data_in;
  logic              fifo_empty;
  logic              fifo_dataline_available;
  logic              get_next_word;
  logic [DATA_W-1:0] fifo_data_out;

  modport slave (
    input  FR_RXF, usb3_data_in, get_next_word,
    output FT_OE, FT_RD, fifo_empty, fifo_dataline_available, fifo_data_out
  );

  modport master (
    output FR_RXF, usb3_data_in, get_next_word,
    input  FT_OE, FT_RD, fifo_empty, fifo_dataline_available, fifo_data_out
  );
endinterface
`default_nettype wire

// File: rtl/usb3_if_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// sync_fifo_fwft : single-clock first-word-fall-through FIFO
// Revision       : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic [DATA_W-1:0]        din,
  output logic      [DATA_W-1:0]        dout,
  output logic      [$clog2(DEPTH):0]   count,
  output logic                          empty,
  output logic                          full
);
  localparam int                c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]     c_full    = (c_aw+1)'(DEPTH);
  localparam logic [c_aw:0]     c_cnt_one = (c_aw+1)'(1);
  localparam logic [c_aw-1:0]   c_ptr_one = c_aw'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign empty = (r_count == '0);
  assign full  = (r_count == c_full);
  assign count = r_count;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/usb3_if.sv
`default_nettype none
// ============================================================================
// usb3_if : FT60x 245-sync-FIFO receive bridge with FWFT buffering
// Revision: 1.0 - initial release
// ============================================================================
module usb3_if
  import usb3_if_pkg::*;
#(
  parameter int DATA_W     = c_data_w,
  parameter int DEPTH      = 32,
  parameter int LINE_WORDS = 8,
  parameter int AF_MARGIN  = 2
) (
  input  wire logic ftdi_clk,
  input  wire logic reset,
  input  wire logic fpga_clk,
  usb3_if_if.slave  bus
);
  localparam int            c_aw     = $clog2(DEPTH);
  localparam logic [c_aw:0] c_depth  = (c_aw+1)'(DEPTH);
  localparam logic [c_aw:0] c_margin = (c_aw+1)'(AF_MARGIN);
  localparam logic [c_aw:0] c_line   = (c_aw+1)'(LINE_WORDS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ft_oe;
  logic              r_ft_rd;
  logic              w_oe_nxt;
  logic              w_rd_nxt;
  logic [c_aw:0]     w_count;
  logic [c_aw:0]     w_free;
  logic              w_room;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic [DATA_W-1:0] w_dout;
  logic              w_unused;

  assign w_unused = fpga_clk ^ w_full;

  assign w_free = c_depth - w_count;
  assign w_room = (w_free > c_margin);
  assign w_push = ~r_ft_rd & ~bus.FR_RXF;

  always_ff @(posedge ftdi_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!bus.FR_RXF && w_room)  w_state_nxt = ST_OE;
      ST_OE:                               w_state_nxt = ST_READ;
      ST_READ: if (bus.FR_RXF || !w_room)  w_state_nxt = ST_STOP;
      ST_STOP:                             w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they toggle on the transition edge.
  always_comb begin
    w_oe_nxt = 1'b1;
    w_rd_nxt = 1'b1;
    case (w_state_nxt)
      ST_OE:   w_oe_nxt = 1'b0;
      ST_READ: begin
        w_oe_nxt = 1'b0;
        w_rd_nxt = 1'b0;
      end
      ST_STOP: w_oe_nxt = 1'b0;
      default: begin
        w_oe_nxt = 1'b1;
        w_rd_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge ftdi_clk or posedge reset) begin
    if (reset) begin
      r_ft_oe <= 1'b1;
      r_ft_rd <= 1'b1;
    end else begin
      r_ft_oe <= w_oe_nxt;
      r_ft_rd <= w_rd_nxt;
    end
  end

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (ftdi_clk),
    .rst   (reset),
    .push  (w_push),
    .pop   (bus.get_next_word),
    .din   (bus.usb3_data_in),
    .dout  (w_dout),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );

  assign bus.FT_OE                   = r_ft_oe;
  assign bus.FT_RD                   = r_ft_rd;
  assign bus.fifo_empty              = w_empty;
  assign bus.fifo_dataline_available = (w_count >= c_line);
  assign bus.fifo_data_out           = w_dout;

endmodule
`default_nettype wire

// File: tb/tb_usb3_if.sv
`default_nettype none
// ============================================================================
// tb_usb3_if : randomized scoreboard bench for the FT60x receive bridge
// Revision   : 1.0 - initial release
// ============================================================================
module tb_usb3_if;
  localparam int DATA_W     = 32;
  localparam int DEPTH      = 32;
  localparam int LINE_WORDS = 8;

  logic ftdi_clk = 1'b0;
  logic fpga_clk = 1'b0;
  logic reset    = 1'b1;

  usb3_if_if #(.DATA_W(DATA_W)) bus ();

  usb3_if #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .LINE_WORDS (LINE_WORDS),
    .AF_MARGIN  (2)
  ) dut (
    .ftdi_clk (ftdi_clk),
    .reset    (reset),
    .fpga_clk (fpga_clk),
    .bus      (bus)
  );

  always #5 ftdi_clk = ~ftdi_clk;
  always #7 fpga_clk = ~fpga_clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [DATA_W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the FIFO is an ordered queue of captured words. At each
  // falling edge it checks the current flags/head and then applies the
  // capture and pop that the coming rising edge will perform.
  always @(negedge ftdi_clk) begin
    logic was_full;
    if (reset) begin
      exp_q.delete();
    end else begin
      chk("empty_flag", 64'(bus.fifo_empty), 64'(exp_q.size() == 0));
      chk("line_flag", 64'(bus.fifo_dataline_available), 64'(exp_q.size() >= LINE_WORDS));
      chk("head_word", 64'(bus.fifo_data_out), 64'(exp_q.size() == 0 ? '0 : exp_q[0]));
      if (!bus.FT_RD) chk("rd_needs_oe", 64'(bus.FT_OE), 64'(0));
      was_full = (exp_q.size() >= DEPTH);
      if (bus.get_next_word && exp_q.size() > 0) void'(exp_q.pop_front());
      if (!bus.FT_RD && !bus.FR_RXF) begin
        chk("room_at_capture", 64'(was_full), 64'(0));
        if (!was_full) exp_q.push_back(bus.usb3_data_in);
      end
    end
  end

  task automatic step();
    @(posedge ftdi_clk);
    #1;
  endtask

  task automatic burst(input int n);
    bus.FR_RXF = 1'b0;
    step();
    step();
    for (int i = 0; i < n; i++) begin
      bus.usb3_data_in = $urandom;
      step();
    end
    bus.FR_RXF = 1'b1;
    step();
    step();
  endtask

  initial begin
    bus.FR_RXF        = 1'b1;
    bus.get_next_word = 1'b0;
    bus.usb3_data_in  = '0;
    repeat (3) step();
    chk("rst_oe", 64'(bus.FT_OE), 64'(1));
    chk("rst_rd", 64'(bus.FT_RD), 64'(1));
    chk("rst_empty", 64'(bus.fifo_empty), 64'(1));
    chk("rst_dout", 64'(bus.fifo_data_out), 64'(0));
    chk("rst_line", 64'(bus.fifo_dataline_available), 64'(0));
    reset = 1'b0;
    step();
    step();

    // Single burst: RXF falls after edge N
    bus.FR_RXF       = 1'b0;
    bus.usb3_data_in = 32'hDEAD0000;
    step();
    chk("oe_at_n1", 64'(bus.FT_OE), 64'(0));
    chk("rd_at_n1", 64'(bus.FT_RD), 64'(1));
    step();
    chk("rd_at_n2", 64'(bus.FT_RD), 64'(0));
    bus.usb3_data_in = 32'h11111111;
    for (int i = 2; i <= 4; i++) begin
      step();
      bus.usb3_data_in = 32'h11111111 * i;
    end
    step();
    bus.FR_RXF = 1'b1;
    step();
    chk("stop_rd", 64'(bus.FT_RD), 64'(1));
    chk("stop_oe", 64'(bus.FT_OE), 64'(0));
    step();
    chk("idle_oe", 64'(bus.FT_OE), 64'(1));
    chk("burst_words", 64'(exp_q.size()), 64'(4));
    chk("burst_head", 64'(bus.fifo_data_out), 64'h11111111);
    chk("burst_nonempty", 64'(bus.fifo_empty), 64'(0));

    // Line flag: four more words reach the line threshold, one pop drops it
    burst(4);
    chk("line_up", 64'(bus.fifo_dataline_available), 64'(1));
    bus.get_next_word = 1'b1;
    step();
    bus.get_next_word = 1'b0;
    chk("line_down", 64'(bus.fifo_dataline_available), 64'(0));

    // Flow control: data always pending, nobody popping
    bus.FR_RXF = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus.usb3_data_in = $urandom;
      step();
    end
    chk("fc_rd_high", 64'(bus.FT_RD), 64'(1));
    chk("fc_oe_high", 64'(bus.FT_OE), 64'(1));
    chk("fc_level", 64'(exp_q.size() >= 30 && exp_q.size() <= DEPTH), 64'(1));
    bus.FR_RXF = 1'b1;

    // Drain past empty
    bus.get_next_word = 1'b1;
    repeat (40) step();
    bus.get_next_word = 1'b0;
    chk("drain_empty", 64'(bus.fifo_empty), 64'(1));
    chk("drain_dout", 64'(bus.fifo_data_out), 64'(0));

    // Simultaneous push/pop while streaming
    burst(3);
    bus.FR_RXF        = 1'b0;
    bus.get_next_word = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.usb3_data_in = $urandom;
      step();
    end
    bus.FR_RXF        = 1'b1;
    bus.get_next_word = 1'b0;
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.FR_RXF        = ($urandom_range(0, 3) == 0);
      bus.get_next_word = ($urandom_range(0, 2) != 0);
      bus.usb3_data_in  = $urandom;
      step();
    end
    bus.FR_RXF        = 1'b1;
    bus.get_next_word = 1'b0;
    step();

    // Reset during READ
    bus.FR_RXF = 1'b0;
    repeat (5) step();
    chk("pre_rst_rd", 64'(bus.FT_RD), 64'(0));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_oe", 64'(bus.FT_OE), 64'(1));
    chk("arst_rd", 64'(bus.FT_RD), 64'(1));
    chk("arst_empty", 64'(bus.fifo_empty), 64'(1));
    bus.FR_RXF = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    // Recovery burst then drain
    burst(5);
    bus.get_next_word = 1'b1;
    repeat (8) step();
    bus.get_next_word = 1'b0;
    step();
    chk("final_empty", 64'(bus.fifo_empty), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
